ws2812_rx: RTL and testbench
============================

WS2812_RX -- requirements
Module: ws2812_rx

Interface
REQ-001 Parameter T_GLITCH, default 4: minimum valid high width in clk cycles; shorter highs are errors.
REQ-002 Parameter T_SPLIT, default 17: high width at or above this decodes as 1, below decodes as 0.
REQ-003 Parameter T_HMAX, default 40: high width above this is an error.
REQ-004 Parameter T_RESET, default 1350: low width in cycles that counts as the latch/reset gap (50 us at 27 MHz).
REQ-005 clk  input  1: single clock, 27 MHz nominal, all logic on the rising edge.
REQ-006 rst  input  1: asynchronous, active-high reset.
REQ-007 WS2812  input  1: serial data line, asynchronous to clk.
REQ-008 rgb  output  24: last decoded pixel as {R,G,B}.
REQ-009 pixel_valid  output  1: one-cycle strobe, rgb and pixel_idx are valid.
REQ-010 pixel_idx  output  8: position of the pixel in the current frame, 0-based.
REQ-011 frame_end  output  1: one-cycle strobe on a detected reset gap that ends a non-empty frame.
REQ-012 err  output  1: one-cycle strobe on a protocol violation.

Function
REQ-013 WS2812 shall pass through a 2-FF synchronizer; all timing below refers to the synchronized signal d and its previous value d_q.
REQ-014 States: SYNC, LOW, HIGH.
REQ-015 SYNC: ignore bits and count consecutive low cycles; at count = T_RESET go to LOW with bit and pixel counters cleared; no frame_end from SYNC.
REQ-016 SYNC: a high sample before T_RESET clears the low count and stays in SYNC.
REQ-017 LOW: rising edge (d=1, d_q=0) goes to HIGH with high counter = 1.
REQ-018 LOW: low counter (11 bits, saturating) reaching T_RESET ends the frame.
REQ-019 Frame end, bit count 0 and at least one pixel since the last frame end: pulse frame_end, clear pixel_idx.
REQ-020 Frame end, bit count nonzero: pulse err, discard the partial bits, and clear the bit count and pixel_idx.
REQ-021 Frame end, no bits received: no strobe.
REQ-022 HIGH: the high counter increments each cycle d=1 and saturates at T_HMAX+1.
REQ-023 HIGH, counter exceeding T_HMAX: pulse err once, go to SYNC.
REQ-024 HIGH, falling edge: if high width < T_GLITCH, pulse err and go to SYNC.
REQ-025 HIGH, falling edge, otherwise: shift bit (width >= T_SPLIT) MSB-first into a 24-bit shift register, increment the 5-bit bit count, clear the low counter, go to LOW.
REQ-026 Stream order is G[7:0], R[7:0], B[7:0]; rgb = {sh[15:8], sh[23:16], sh[7:0]}.
REQ-027 On the 24th bit: load rgb, pulse pixel_valid, clear the bit count.
REQ-028 pixel_valid shall assert on the cycle after the falling edge of the 24th bit is seen on d.
REQ-029 On each pixel_valid, pixel_idx holds that pixel's index and then increments; it saturates at 255 without wrapping, and further pixels repeat index 255.
REQ-030 pixel_valid, frame_end and err are mutually exclusive within a cycle; at most one fires per edge or timeout event.
REQ-031 rgb holds its value between strobes.
REQ-032 Low time between bits is not checked beyond the T_RESET gap.

Reset
REQ-033 While rst=1: state = SYNC; rgb = 0; pixel_idx = 0; pixel_valid = frame_end = err = 0; all counters and the synchronizer = 0.
REQ-034 rst asserted mid-frame shall drop the partial pixel with no strobe.
REQ-035 After rst, a full T_RESET low gap is required before the first bit is accepted.

Verification
REQ-036 After rst, 1350 low cycles, then 24 bits encoding G=0x12 R=0x34 B=0x56 (0: 11H/21L; 1: 23H/9L) -> one pixel_valid, rgb=0x341256, pixel_idx=0.
REQ-037 Three pixels, then 1400 low cycles -> pixel_idx 0, 1, 2 on the strobes, then one frame_end; the next pixel is reported with pixel_idx=0.
REQ-038 10 bits, then a 1400-cycle low gap -> err pulse, no pixel_valid, no frame_end; the next full pixel has pixel_idx=0.
REQ-039 A 2-cycle high glitch mid-pixel -> err, then no pixel_valid until 1350 low cycles followed by 24 new bits.
REQ-040 High held for 60 cycles -> exactly one err at high count 41, state SYNC.
REQ-041 Data starting without a preceding gap after rst -> no strobes; rst pulse mid-pixel -> outputs zero, no strobe.

Source files
------------

// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812 serial line decoder producing 24-bit pixels, frame-end and error strobes
module ws2812_rx #(
  parameter int T_GLITCH = 4,
  parameter int T_SPLIT  = 17,
  parameter int T_HMAX   = 40,
  parameter int T_RESET  = 1350
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WS2812,
  output logic [23:0] rgb,
  output logic        pixel_valid,
  output logic [7:0]  pixel_idx,
  output logic        frame_end,
  output logic        err
);
  localparam int HW = $clog2(T_HMAX + 2);
  typedef enum logic [1:0] {SYNC, LOW, HIGH} state_t;
  state_t          state;
  logic            s1, d, d_q, seen;
  logic [10:0]     lcnt;
  logic [HW-1:0]   hcnt;
  logic [4:0]      bcnt;
  logic [7:0]      nidx;
  logic [23:0]     sh, sh_n;
  logic [10:0]     lcnt_inc;
  assign sh_n = {sh[22:0], hcnt >= HW'(T_SPLIT)};
  assign lcnt_inc = (lcnt == '1) ? lcnt : lcnt + 11'd1;
  // two-stage synchronizer plus one-cycle history for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) {s1, d, d_q} <= '0;
    else {s1, d, d_q} <= {WS2812, s1, d};
  end
  // bit timing, pixel assembly and frame tracking; all strobes registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SYNC;
      rgb <= '0;
      pixel_idx <= '0;
      pixel_valid <= 1'b0;
      frame_end <= 1'b0;
      err <= 1'b0;
      lcnt <= '0;
      hcnt <= '0;
      bcnt <= '0;
      nidx <= '0;
      sh <= '0;
      seen <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_end <= 1'b0;
      err <= 1'b0;
      case (state)
        SYNC: begin
          if (d) lcnt <= '0;
          else begin
            lcnt <= lcnt_inc;
            if (lcnt == 11'(T_RESET - 1)) begin
              state <= LOW;
              bcnt <= '0;
              nidx <= '0;
              pixel_idx <= '0;
              seen <= 1'b0;
            end
          end
        end
        LOW: begin
          if (d && !d_q) begin
            state <= HIGH;
            hcnt <= HW'(1);
          end else if (!d) begin
            lcnt <= lcnt_inc;
            if (lcnt == 11'(T_RESET - 1)) begin
              bcnt <= '0;
              nidx <= '0;
              pixel_idx <= '0;
              seen <= 1'b0;
              if (bcnt != 5'd0) err <= 1'b1;
              else if (seen) frame_end <= 1'b1;
            end
          end
        end
        HIGH: begin
          if (d) begin
            hcnt <= (hcnt > HW'(T_HMAX)) ? hcnt : hcnt + HW'(1);
            if (hcnt == HW'(T_HMAX)) begin
              err <= 1'b1;
              state <= SYNC;
              lcnt <= '0;
            end
          end else if (hcnt < HW'(T_GLITCH)) begin
            err <= 1'b1;
            state <= SYNC;
            lcnt <= '0;
          end else begin
            sh <= sh_n;
            lcnt <= '0;
            state <= LOW;
            if (bcnt == 5'd23) begin
              bcnt <= '0;
              rgb <= {sh_n[15:8], sh_n[23:16], sh_n[7:0]};
              pixel_valid <= 1'b1;
              pixel_idx <= nidx;
              nidx <= (nidx == 8'hff) ? nidx : nidx + 8'd1;
              seen <= 1'b1;
            end else bcnt <= bcnt + 5'd1;
          end
        end
        default: state <= SYNC;
      endcase
    end
  end
endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx: directed bench for the WS2812 decoder
`timescale 1ns/1ps
module tb_ws2812_rx;
  logic        clk = 0, rst = 1, ws = 0;
  logic [23:0] rgb;
  logic        pixel_valid, frame_end, err;
  logic [7:0]  pixel_idx;
  int          n_chk = 0, n_pass = 0;
  int          pv_cnt = 0, fe_cnt = 0, err_cnt = 0, multi_cnt = 0;
  logic [23:0] last_rgb = '0;
  int          idx_q[$];

  ws2812_rx dut (
    .clk(clk), .rst(rst), .WS2812(ws), .rgb(rgb), .pixel_valid(pixel_valid),
    .pixel_idx(pixel_idx), .frame_end(frame_end), .err(err)
  );

  always #18.5 clk = ~clk;

  // strobe monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (pixel_valid) begin
      pv_cnt++;
      last_rgb = rgb;
      idx_q.push_back(int'(pixel_idx));
    end
    if (frame_end) fe_cnt++;
    if (err) err_cnt++;
    if (int'(pixel_valid) + int'(frame_end) + int'(err) > 1) multi_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clear();
    pv_cnt = 0; fe_cnt = 0; err_cnt = 0; idx_q.delete();
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic gap(input int n);
    ws = 0; cyc(n);
  endtask

  task automatic send_bit(input logic b);
    ws = 1; cyc(b ? 23 : 11);
    ws = 0; cyc(b ? 9 : 21);
  endtask

  task automatic send_bits(input logic [23:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_pixel(input logic [7:0] g, input logic [7:0] r, input logic [7:0] b);
    send_bits({g, r, b}, 24);
  endtask

  initial begin
    cyc(5);
    chk("rst_rgb", rgb, 0);
    chk("rst_idx", pixel_idx, 0);
    chk("rst_strobes", {pixel_valid, frame_end, err}, 0);
    rst = 0;
    // single pixel after the startup gap
    gap(1360);
    send_pixel(8'h12, 8'h34, 8'h56);
    chk("p0_count", pv_cnt, 1);
    chk("p0_rgb", last_rgb, 24'h341256);
    chk("p0_idx", idx_q[0], 0);
    chk("p0_err", err_cnt, 0);
    gap(50);
    chk("rgb_hold", rgb, 24'h341256);
    // three pixels in one frame, then a frame end
    send_pixel(8'ha1, 8'hb2, 8'hc3);
    send_pixel(8'hff, 8'h00, 8'h81);
    gap(1400);
    chk("f3_count", pv_cnt, 3);
    chk("f3_idx1", idx_q[1], 1);
    chk("f3_idx2", idx_q[2], 2);
    chk("f3_rgb", last_rgb, 24'h00ff81);
    chk("f3_fe", fe_cnt, 1);
    chk("f3_err", err_cnt, 0);
    chk("f3_idx_clr", pixel_idx, 0);
    clear();
    send_pixel(8'h01, 8'h02, 8'h03);
    chk("nf_idx", idx_q[0], 0);
    chk("nf_rgb", last_rgb, 24'h020103);
    gap(1400);
    chk("nf_fe", fe_cnt, 1);
    // partial pixel ended by a gap
    clear();
    send_bits(24'h2aa, 10);
    gap(1400);
    chk("part_err", err_cnt, 1);
    chk("part_pv", pv_cnt, 0);
    chk("part_fe", fe_cnt, 0);
    send_pixel(8'h55, 8'h66, 8'h77);
    chk("part_next_idx", idx_q[0], 0);
    chk("part_next_rgb", last_rgb, 24'h665577);
    gap(1400);
    chk("part_next_fe", fe_cnt, 1);
    // short glitch forces resynchronisation
    clear();
    send_bits(24'h15, 5);
    ws = 1; cyc(2); ws = 0; cyc(10);
    send_pixel(8'hde, 8'had, 8'hbe);
    chk("gl_err", err_cnt, 1);
    chk("gl_pv", pv_cnt, 0);
    gap(1360);
    send_pixel(8'h0a, 8'h0b, 8'h0c);
    chk("gl_pv_after", pv_cnt, 1);
    chk("gl_idx", idx_q[0], 0);
    chk("gl_rgb", last_rgb, 24'h0b0a0c);
    // overlong high
    clear();
    ws = 1; cyc(60); ws = 0; cyc(20);
    chk("long_err", err_cnt, 1);
    send_pixel(8'h11, 8'h22, 8'h33);
    chk("long_sync_pv", pv_cnt, 0);
    chk("long_err_once", err_cnt, 1);
    // data without a gap after reset
    rst = 1; cyc(2); rst = 0;
    clear();
    send_pixel(8'h44, 8'h55, 8'h66);
    chk("nogap_pv", pv_cnt, 0);
    chk("nogap_err", err_cnt, 0);
    // reset mid-pixel
    gap(1360);
    send_pixel(8'h10, 8'h20, 8'h30);
    chk("pre_rst_rgb", last_rgb, 24'h201030);
    send_bits(24'h3ff, 10);
    ws = 1; cyc(5);
    rst = 1; cyc(2);
    chk("mid_rst_rgb", rgb, 0);
    chk("mid_rst_idx", pixel_idx, 0);
    chk("mid_rst_strobes", {pixel_valid, frame_end, err}, 0);
    ws = 0; rst = 0; cyc(40);
    chk("mid_rst_pv", pv_cnt, 1);
    chk("mid_rst_err", err_cnt, 0);
    chk("exclusive", multi_cnt, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
